// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch redirect and stall controller.
//
// Chooses the PC source each cycle from three redirect sources (EX-stage
// taken branch, ID-stage jump, ID-stage jump-register) and the load-use
// hazard. When a redirect arrives while the instruction memory is not
// ready, it is latched and the block waits in PEND. When memory becomes
// ready the latched redirect is applied and the stale fetch is flushed.
//
// Optional feature: define FETCH_CTRL_PERF_EN to add the Stall_Count and
// Redirect_Count performance counter outputs.
//
// Outputs are combinational because redirects must take effect with zero
// added latency. Only the FSM state, the pending redirect and the counters
// are registered.

module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        IMem_Ready,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [25:0] Jump_Target,
  input  logic        JumpR,
  input  logic [31:0] Jump_RegTarget,
  input  logic        Load_Use_Hazard,
  output logic [1:0]  PCSrc,
  output logic        PC_Write,
  output logic [31:0] Branch_Target_Out,
  output logic [25:0] Jump_Target_Out,
  output logic [31:0] Jump_RegTarget_Out,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        IMem_Req
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] Stall_Count,
  output logic [31:0] Redirect_Count
`endif
);

  // PC source encodings; also used as the kind of a latched redirect.
  localparam logic [1:0] KIND_SEQ  = 2'b00;
  localparam logic [1:0] KIND_JUMP = 2'b01;
  localparam logic [1:0] KIND_JR   = 2'b10;
  localparam logic [1:0] KIND_BR   = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  pend_kind_q, pend_kind_d;
  logic [31:0] pend_target_q, pend_target_d;

  // Prioritised redirect request seen by the RUN state.
  logic        req_valid_s;
  logic [1:0]  req_kind_s;
  logic [31:0] req_target_s;
  logic        stall_s;

  // Effective redirect in PEND: a new branch replaces the latched one.
  logic [1:0]  eff_kind_s;
  logic [31:0] eff_target_s;

  // Decode the redirect sources: branch beats hazard, hazard blocks jumps.
  always_comb begin
    req_valid_s  = 1'b0;
    req_kind_s   = KIND_SEQ;
    req_target_s = 32'd0;
    stall_s      = 1'b0;
    if (Branch_Taken) begin
      req_valid_s  = 1'b1;
      req_kind_s   = KIND_BR;
      req_target_s = Branch_Target;
    end else if (Load_Use_Hazard) begin
      stall_s = 1'b1;
    end else if (Jump) begin
      req_valid_s  = 1'b1;
      req_kind_s   = KIND_JUMP;
      req_target_s = {6'd0, Jump_Target};
    end else if (JumpR) begin
      req_valid_s  = 1'b1;
      req_kind_s   = KIND_JR;
      req_target_s = Jump_RegTarget;
    end else begin
      req_valid_s = 1'b0;
    end
  end

  // Select the redirect that applies while pending; jumps are on a flushed path.
  always_comb begin
    if (Branch_Taken) begin
      eff_kind_s   = KIND_BR;
      eff_target_s = Branch_Target;
    end else begin
      eff_kind_s   = pend_kind_q;
      eff_target_s = pend_target_q;
    end
  end

  // Next-state and output logic for the RUN/PEND controller.
  always_comb begin
    state_d            = state_q;
    pend_kind_d        = pend_kind_q;
    pend_target_d      = pend_target_q;
    PCSrc              = KIND_SEQ;
    PC_Write           = 1'b0;
    IF_ID_Write        = 1'b0;
    IF_ID_Flush        = 1'b0;
    ID_EX_Flush        = 1'b0;
    IMem_Req           = 1'b0;
    Branch_Target_Out  = Branch_Target;
    Jump_Target_Out    = Jump_Target;
    Jump_RegTarget_Out = Jump_RegTarget;

    if (reset) begin
      state_d       = RUN;
      pend_kind_d   = KIND_SEQ;
      pend_target_d = 32'd0;
    end else begin
      IMem_Req    = 1'b1;
      IF_ID_Write = IMem_Ready;
      case (state_q)
        RUN: begin
          if (stall_s) begin
            // Hold PC and IF/ID, insert a bubble into EX.
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end else if (req_valid_s) begin
            // Flushes go out in the event cycle whether or not memory is ready.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = (req_kind_s == KIND_BR);
            PCSrc       = req_kind_s;
            if (IMem_Ready) begin
              PC_Write = 1'b1;
            end else begin
              PC_Write      = 1'b0;
              pend_kind_d   = req_kind_s;
              pend_target_d = req_target_s;
              state_d       = PEND;
            end
          end else begin
            PC_Write = IMem_Ready;
          end
        end
        PEND: begin
          PCSrc              = eff_kind_s;
          Branch_Target_Out  = eff_target_s;
          Jump_Target_Out    = eff_target_s[25:0];
          Jump_RegTarget_Out = eff_target_s;
          if (Branch_Taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else begin
            ID_EX_Flush = 1'b0;
          end
          if (IMem_Ready) begin
            // Apply the redirect and drop the stale instruction just fetched.
            PC_Write      = 1'b1;
            IF_ID_Flush   = 1'b1;
            state_d       = RUN;
            pend_kind_d   = KIND_SEQ;
            pend_target_d = 32'd0;
          end else begin
            PC_Write      = 1'b0;
            pend_kind_d   = eff_kind_s;
            pend_target_d = eff_target_s;
          end
        end
        default: begin
          state_d       = RUN;
          pend_kind_d   = KIND_SEQ;
          pend_target_d = 32'd0;
        end
      endcase
    end
  end

  // State and pending-redirect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pend_kind_q   <= KIND_SEQ;
      pend_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pend_kind_q   <= pend_kind_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  // Counter increments: stalled cycles and applied non-sequential PC updates.
  always_comb begin
    stall_count_d    = stall_count_q;
    redirect_count_d = redirect_count_q;
    if (!PC_Write) begin
      stall_count_d = stall_count_q + 32'd1;
    end else if (PCSrc != KIND_SEQ) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end else begin
      redirect_count_d = redirect_count_q;
    end
  end

  // Performance counter registers; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q    <= 32'd0;
      redirect_count_q <= 32'd0;
    end else begin
      stall_count_q    <= stall_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign Stall_Count    = stall_count_q;
  assign Redirect_Count = redirect_count_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 IMem_Ready  input  1  instruction for the current PC is valid this cycle.
REQ-004 Branch_Taken  input  1  EX-stage taken-branch pulse.
REQ-005 Branch_Target  input  32  EX-stage branch target.
REQ-006 Jump  input  1  ID-stage J/JAL pulse.
REQ-007 Jump_Target  input  26  ID-stage jump index.
REQ-008 JumpR  input  1  ID-stage JR/JALR pulse.
REQ-009 Jump_RegTarget  input  32  ID-stage register target.
REQ-010 Load_Use_Hazard  input  1  ID instruction depends on a load in EX.
REQ-011 PCSrc  output  2  encoding: 00 PC+4, 01 jump, 10 jump-register, 11 branch.
REQ-012 PC_Write  output  1  PC update enable.
REQ-013 Branch_Target_Out / Jump_Target_Out / Jump_RegTarget_Out  output  32/26/32  targets presented to the PC.
REQ-014 IF_ID_Write, IF_ID_Flush, ID_EX_Flush  output  1 each  pipeline register control.
REQ-015 IMem_Req  output  1  fetch request for the current PC.

Function
REQ-016 The block SHALL have two states, RUN and PEND; PEND holds exactly one latched redirect (2-bit kind plus 32-bit target).
REQ-017 Redirect priority SHALL be Branch_Taken > Jump > JumpR in the same cycle.
REQ-018 In RUN with IMem_Ready=1 and no redirect or hazard, PCSrc SHALL be 00 and PC_Write SHALL be 1, with zero added latency.
REQ-019 In RUN, when a redirect occurs with IMem_Ready=1, the block SHALL drive PCSrc=kind, PC_Write=1, and pass the targets through in the same cycle.
REQ-020 In RUN, when a redirect occurs with IMem_Ready=0, the block SHALL drive PC_Write=0, latch kind and target, and enter PEND on the next edge.
REQ-021 Flush rules: a branch SHALL assert IF_ID_Flush and ID_EX_Flush; Jump/JumpR SHALL assert IF_ID_Flush only.
REQ-022 Flushes SHALL be asserted in the event cycle regardless of IMem_Ready.
REQ-023 In PEND, PCSrc SHALL equal the latched kind and all *_Out targets SHALL come from the latched target (Jump_Target_Out = bits [25:0]).
REQ-024 In PEND, PC_Write and IF_ID_Flush SHALL be 1 in the cycle IMem_Ready=1 (the stale fetch is discarded), followed by a return to RUN.
REQ-025 In PEND, a new Branch_Taken SHALL overwrite the latched redirect; it SHALL apply the same cycle if IMem_Ready=1.
REQ-026 In PEND, Jump/JumpR SHALL be ignored, because they originate on a flushed path.
REQ-027 On Load_Use_Hazard without Branch_Taken, the block SHALL drive PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, and suppress Jump/JumpR that cycle.
REQ-028 Branch_Taken SHALL override Load_Use_Hazard.
REQ-029 IF_ID_Write SHALL be 0 whenever IMem_Ready=0 and 1 otherwise, except under REQ-027.
REQ-030 IMem_Req SHALL be 1 in every non-reset cycle.

Reset
REQ-031 While reset=1: state=RUN, pending cleared, PCSrc=00, PC_Write=0, all flushes 0, IF_ID_Write=0, IMem_Req=0, and counters 0.
REQ-032 Reset asserted in PEND SHALL discard the pending redirect with no PC_Write on the following cycle.

Configuration
REQ-033 With FETCH_CTRL_PERF_EN defined, the block SHALL add outputs Stall_Count[31:0] and Redirect_Count[31:0].
REQ-034 Stall_Count SHALL increment on every cycle with PC_Write=0 outside reset.
REQ-035 Redirect_Count SHALL increment on every cycle with PC_Write=1 and PCSrc!=00.
REQ-036 Both counters SHALL wrap at 2^32.
REQ-037 Without the macro, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Reset 3 cycles, then IMem_Ready=1 constantly -> PC_Write=1 and PCSrc=00 every cycle; PC steps 0x00400000, 0x00400004, 0x00400008.
REQ-039 Branch_Taken=1, Branch_Target=0x00400100, IMem_Ready=1 -> same cycle PCSrc=11, PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
REQ-040 Jump=1, Jump_Target=0x0100040, IMem_Ready=0 for 3 cycles then 1 -> PC_Write=0 for 3 cycles, then PCSrc=01, Jump_Target_Out=0x0100040, PC_Write=1, IF_ID_Flush=1.
REQ-041 PEND holding a jump, then Branch_Taken with target 0x00400200 while IMem_Ready=0 -> on ready, PCSrc=11, Branch_Target_Out=0x00400200; a later Jump in PEND is ignored.
REQ-042 Load_Use_Hazard and JumpR in the same cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0; with Branch_Taken added -> branch taken.
REQ-043 Reset during PEND, then IMem_Ready=1 -> first post-reset cycle has PCSrc=00; with FETCH_CTRL_PERF_EN, counters read 0 after reset.
